clkdiv_ctrl: RTL and testbench
==============================

# clkdiv_ctrl

Programmable clock-enable controller that sequences the system clock divider: owns the divide ratio, starts and stops division on period boundaries, and accepts new ratios through a valid/ready handshake. Changes take effect only at a period boundary, so no runt pulse ever appears. Sits between the CSR/boot logic and the core clock-enable fan-out, and produces both a one-cycle enable strobe and a square-wave `CLK_OUT`.

## Interface
- `W`, 8: width of the divide ratio and period counter.
- `DEFAULT_DIV`, 4: ratio loaded at reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^W-1.
- `CLK` in 1: single clock; all logic on its rising edge.
- `RES` in 1: reset; synchronous and active-low (0 = reset).
- `EN` in 1: run request; level-sensitive.
- `CFG_VALID` in 1: new ratio offered.
- `CFG_DIV` in W: offered ratio N.
- `CFG_READY` out 1: controller can accept a ratio.
- `CE` out 1: one-cycle strobe, once per period.
- `CLK_OUT` out 1: divided square wave.
- `ACTIVE` out 1: the controller is dividing (state RUN or PEND).
- `CUR_DIV` out W: ratio currently in force.

## Operation
- States: IDLE, RUN, PEND. Registers: `state`, `cnt[W-1:0]`, `cur_div`, `pend_div`.
- Ratio clamp: a `CFG_DIV` of 0 or 1 is stored as 2. Any other value is stored unchanged. Maximum ratio is 2^W-1.
- Handshake: a transfer occurs when `CFG_VALID && CFG_READY` at a rising edge. `CFG_READY` = (state != PEND) and is decoded from `state` only.
- IDLE:
  - `cnt` is held at 0; `CE` = `CLK_OUT` = 0.
  - A transfer writes `cur_div` directly.
  - `EN` = 1 moves to RUN with `cnt` = 0.
  - If a transfer and `EN` rise occur together, the new ratio is used for the first period.
- RUN:
  - `cnt` increments each cycle and wraps from `cur_div`-1 to 0.
  - A transfer writes `pend_div` and moves to PEND.
  - At the boundary (`cnt` == `cur_div`-1) with `EN` = 0, the controller returns to IDLE.
- PEND:
  - Counting continues under the old ratio.
  - At the boundary: `cur_div` <= `pend_div`, `cnt` <= 0.
  - Next state is RUN if `EN` = 1, otherwise IDLE.
- Outputs are decoded from registers only; there is no combinational path from inputs.
  - `CE` = ACTIVE && (`cnt` == `cur_div`-1).
  - `CLK_OUT` = ACTIVE && (`cnt` >= `cur_div`>>1). It is low for floor(N/2) cycles, then high for ceil(N/2) cycles.
  - `ACTIVE` = (state != IDLE).

## Timing
- Reset values: state IDLE, `cnt` 0, `cur_div` DEFAULT_DIV, `pend_div` DEFAULT_DIV, `CE` 0, `CLK_OUT` 0, `ACTIVE` 0, `CFG_READY` 1, `CUR_DIV` DEFAULT_DIV.
- Start-up: `EN` is sampled 1 in IDLE at edge k. `ACTIVE` = 1 from k+1, and the first `CE` is in cycle k+N (counting cycle k+1 as the first).
- Reconfiguration: a transfer accepted at edge k in RUN drops `CFG_READY` from k+1. The new ratio is in force from the edge that ends the current period. `CFG_READY` returns high in that same cycle.
- Stopping: when `EN` falls mid-period, the current period completes including its `CE`. `ACTIVE` falls on the edge after that `CE` cycle.
- An `EN` pulse shorter than one period still produces at least one full period.
- Reset mid-operation: `RES` = 0 at any edge forces reset values at that edge. Any pending ratio is discarded.
- `CE` is never asserted in two consecutive cycles; the minimum spacing is 2 cycles.

## Structure
- Package `clkdiv_pkg`: the state enum (`CD_IDLE`, `CD_RUN`, `CD_PEND`), `CD_MIN_DIV` = 2, and the clamp function `cd_clamp(div)`.
- One sub-module, `clkdiv_counter`: the wrap counter with `clr` and `en` inputs and a `last` output (`cnt` == limit-1). The FSM and handshake stay in the top-level module.

## Test plan
- Reset: hold `RES` = 0 for 3 cycles with `EN` = 1 and `CFG_VALID` = 1 → all outputs at reset values, `CUR_DIV` = 4, `CFG_READY` = 1.
- N=4 run: `EN` = 1 → `CLK_OUT` pattern 0,0,1,1 repeating. `CE` is high on every fourth cycle, aligned with the second high cycle of `CLK_OUT`.
- N=5 via IDLE config: offer 5, then `EN` = 1 → `CLK_OUT` pattern 0,0,1,1,1 and `CE` period 5. Then offer `CFG_DIV` = 0 → `CUR_DIV` = 2 and pattern 0,1.
- Mid-period reconfiguration 4→6: accept at `cnt` = 1.
  - `CFG_READY` is 0 for the next 2 cycles.
  - `CUR_DIV` becomes 6 after the boundary.
  - The next `CE` comes 6 cycles after the last 4-period `CE`.
  - A second `CFG_VALID` held during PEND is not accepted until `CFG_READY` returns.
- Stop: drop `EN` at `cnt` = 0 with N=4 → exactly one further `CE` 3 cycles later, then `ACTIVE` = 0 and `CLK_OUT` = 0.
- Reset during PEND: pending ratio 8, `RES` = 0 for 1 cycle → `CUR_DIV` = 4 and state IDLE. Re-enabling runs at N=4.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock-enable divider controller.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        CD_IDLE = 2'd0,
        CD_RUN  = 2'd1,
        CD_PEND = 2'd2
    } cd_state_t;

    localparam int unsigned CD_MIN_DIV = 2;

    // Ratios below two would produce a stuck or every-cycle enable, so they are raised to two.
    function automatic int unsigned cd_clamp(input int unsigned div);
        return (div < CD_MIN_DIV) ? CD_MIN_DIV : div;
    endfunction

endpackage

// File: rtl/clkdiv_ctrl_if.sv
// Ratio configuration handshake between CSR/boot logic and the divider controller.
interface clkdiv_ctrl_if #(
    parameter int W = 8
);
    logic         CFG_VALID;
    logic [W-1:0] CFG_DIV;
    logic         CFG_READY;

    modport master (output CFG_VALID, output CFG_DIV, input CFG_READY);
    modport slave  (input CFG_VALID, input CFG_DIV, output CFG_READY);
endinterface

// File: rtl/clkdiv_counter.sv
// Period counter that wraps from limit-1 back to zero; clr has priority over en.
module clkdiv_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == (limit - W'(1)));

    always_ff @(posedge clk) begin
        if (!res) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Divider controller: owns the ratio, starts/stops and retunes only on period boundaries.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         EN,
    clkdiv_ctrl_if.slave cfg,
    output logic         CE,
    output logic         CLK_OUT,
    output logic         ACTIVE,
    output logic [W-1:0] CUR_DIV
);

    cd_state_t    state;
    cd_state_t    state_next;
    logic [W-1:0] cur_div;
    logic [W-1:0] cur_div_next;
    logic [W-1:0] pend_div;
    logic [W-1:0] pend_div_next;
    logic [W-1:0] cnt;
    logic [W-1:0] new_div;
    logic         cnt_clr;
    logic         cnt_en;
    logic         last;
    logic         xfer;

    assign new_div       = W'(cd_clamp(32'(cfg.CFG_DIV)));
    assign cfg.CFG_READY = (state != CD_PEND);
    assign xfer          = cfg.CFG_VALID && cfg.CFG_READY;

    clkdiv_counter #(.W(W)) u_counter (
        .clk   (CLK),
        .res   (RES),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cur_div),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge CLK) begin
        if (!RES) begin
            state    <= CD_IDLE;
            cur_div  <= W'(DEFAULT_DIV);
            pend_div <= W'(DEFAULT_DIV);
        end else begin
            state    <= state_next;
            cur_div  <= cur_div_next;
            pend_div <= pend_div_next;
        end
    end

    // A ratio accepted while running waits in pend_div until the old period finishes.
    always_comb begin
        state_next    = state;
        cur_div_next  = cur_div;
        pend_div_next = pend_div;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        case (state)
            CD_IDLE: begin
                cnt_clr = 1'b1;
                if (xfer) cur_div_next = new_div;
                if (EN) state_next = CD_RUN;
            end
            CD_RUN: begin
                cnt_en = 1'b1;
                if (xfer) begin
                    pend_div_next = new_div;
                    state_next    = CD_PEND;
                end else if (last && !EN) begin
                    state_next = CD_IDLE;
                end
            end
            CD_PEND: begin
                cnt_en = 1'b1;
                if (last) begin
                    cur_div_next = pend_div;
                    state_next   = EN ? CD_RUN : CD_IDLE;
                end
            end
            default: state_next = CD_IDLE;
        endcase
    end

    assign ACTIVE  = (state != CD_IDLE);
    assign CE      = ACTIVE && last;
    assign CLK_OUT = ACTIVE && (cnt >= (cur_div >> 1));
    assign CUR_DIV = cur_div;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl with hand-computed expected enable and square-wave patterns.
module tb_clkdiv_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RES = 1'b0;
    logic         EN  = 1'b0;
    logic         CE;
    logic         CLK_OUT;
    logic         ACTIVE;
    logic [W-1:0] CUR_DIV;

    int testCount = 0;
    int failCount = 0;

    clkdiv_ctrl_if #(.W(W)) cfg ();

    clkdiv_ctrl #(.W(W), .DEFAULT_DIV(4)) dut (
        .CLK     (CLK),
        .RES     (RES),
        .EN      (EN),
        .cfg     (cfg),
        .CE      (CE),
        .CLK_OUT (CLK_OUT),
        .ACTIVE  (ACTIVE),
        .CUR_DIV (CUR_DIV)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic res, input logic en, input logic valid, input logic [W-1:0] div);
        RES           = res;
        EN            = en;
        cfg.CFG_VALID = valid;
        cfg.CFG_DIV   = div;
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkPattern(input string tag, input int n, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            checkOutput({tag, "_clk_out"}, 32'(CLK_OUT), 32'((i % n) >= (n / 2)));
            checkOutput({tag, "_ce"}, 32'(CE), 32'((i % n) == (n - 1)));
            tick();
        end
    endtask

    initial begin
        // Reset held with run request and config offered
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd9);
        repeat (3) tick();
        checkOutput("rst_ce", 32'(CE), 32'd0);
        checkOutput("rst_clk_out", 32'(CLK_OUT), 32'd0);
        checkOutput("rst_active", 32'(ACTIVE), 32'd0);
        checkOutput("rst_ready", 32'(cfg.CFG_READY), 32'd1);
        checkOutput("rst_cur_div", 32'(CUR_DIV), 32'd4);

        // N=4 run starting from IDLE
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        checkOutput("n4_active", 32'(ACTIVE), 32'd1);
        checkPattern("n4", 4, 8);

        // Stop at cnt=0: one more CE three cycles later, then inactive
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        for (int j = 0; j < 6; j++) begin
            checkOutput("stop_ce", 32'(CE), 32'(j == 3));
            checkOutput("stop_active", 32'(ACTIVE), 32'(j <= 3));
            checkOutput("stop_clk_out", 32'(CLK_OUT), 32'(j == 2 || j == 3));
            tick();
        end

        // N=5 configured while IDLE
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd5);
        tick();
        checkOutput("n5_cur_div", 32'(CUR_DIV), 32'd5);
        checkOutput("n5_idle", 32'(ACTIVE), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        checkPattern("n5", 5, 10);

        // Offer 0 while running: clamped to 2 after the current period
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("clamp_ready_low", 32'(cfg.CFG_READY), 32'd0);
        checkOutput("clamp_old_div", 32'(CUR_DIV), 32'd5);
        repeat (4) tick();
        checkOutput("clamp_cur_div", 32'(CUR_DIV), 32'd2);
        checkPattern("n2", 2, 4);

        // Reset while running returns to defaults
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("midrst_active", 32'(ACTIVE), 32'd0);
        checkOutput("midrst_cur_div", 32'(CUR_DIV), 32'd4);

        // Mid-period reconfiguration 4 -> 6, accepted at cnt=1
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        repeat (5) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd6);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd7);
        checkOutput("recfg_ready_c1", 32'(cfg.CFG_READY), 32'd0);
        checkOutput("recfg_old_div", 32'(CUR_DIV), 32'd4);
        tick();
        checkOutput("recfg_ready_c2", 32'(cfg.CFG_READY), 32'd0);
        checkOutput("recfg_last4_ce", 32'(CE), 32'd1);
        tick();
        checkOutput("recfg_ready_back", 32'(cfg.CFG_READY), 32'd1);
        checkOutput("recfg_cur_div", 32'(CUR_DIV), 32'd6);
        checkOutput("recfg_ce0", 32'(CE), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("recfg2_ready_low", 32'(cfg.CFG_READY), 32'd0);
        checkOutput("recfg2_div_held", 32'(CUR_DIV), 32'd6);
        for (int c = 1; c < 6; c++) begin
            checkOutput("recfg_ce_6", 32'(CE), 32'(c == 5));
            tick();
        end
        checkOutput("recfg2_cur_div", 32'(CUR_DIV), 32'd7);
        checkOutput("recfg2_ready_back", 32'(cfg.CFG_READY), 32'd1);

        // Reset during PEND discards the pending ratio
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd8);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("pendrst_ready_low", 32'(cfg.CFG_READY), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("pendrst_active", 32'(ACTIVE), 32'd0);
        checkOutput("pendrst_cur_div", 32'(CUR_DIV), 32'd4);
        checkOutput("pendrst_ready", 32'(cfg.CFG_READY), 32'd1);
        checkOutput("pendrst_clk_out", 32'(CLK_OUT), 32'd0);
        tick();
        checkOutput("reen_active", 32'(ACTIVE), 32'd1);
        checkPattern("reen_n4", 4, 8);
        checkOutput("reen_cur_div", 32'(CUR_DIV), 32'd4);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
